// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: deframer state encoding,
// frame layout constants and watchdog scaling.
package ps2_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ps2_state_t;

  localparam int FRAME_BITS = 11;
  localparam int PARITY_IDX = 9;
  localparam int STOP_IDX   = 10;

  // Watchdog limit = sysclk_frequency (in 100 kHz units) * 20 -> 200 us.
  localparam int WDOG_MULT  = 20;

  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous first-word-fall-through FIFO; dout shows the oldest entry while not empty.
// A push when full only succeeds if a pop happens in the same cycle.
module ps2_fifo #(
  parameter int depth_log2 = 3,
  parameter int width      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [width-1:0]      din,
  input  logic                  pop,
  output logic [width-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [depth_log2:0]   count
);

  localparam int DEPTH = 2 ** depth_log2;

  logic [width-1:0]      mem [DEPTH];
  logic [depth_log2-1:0] wr_ptr;
  logic [depth_log2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (depth_log2+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero when empty so stale storage never leaks out.
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: sync + glitch filter on the PS/2 clock, 11-bit deframer
// with start/parity/stop checks and watchdog, scancodes buffered in an FWFT FIFO.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int sysclk_frequency = 1000,
  parameter int filter_len       = 8,
  parameter int fifo_depth_log2  = 3
) (
  input  logic                       clk,
  input  logic                       reset_in,
  input  logic                       ps2_clk_in,
  input  logic                       ps2_dat_in,
  input  logic                       rd,
  output logic [7:0]                 data,
  output logic                       valid,
  output logic [fifo_depth_log2:0]   fifo_count,
  output logic                       parity_err,
  output logic                       frame_err,
  output logic                       overflow,
  input  logic                       err_clr
);

  localparam int WD_LIMIT = sysclk_frequency * WDOG_MULT;
  localparam int WD_W     = $clog2(WD_LIMIT + 1);
  localparam int FLT_W    = $clog2(filter_len + 1);

  logic [1:0]       clk_sync;
  logic [1:0]       dat_sync;
  logic             clk_s;
  logic             dat_s;
  logic             filt;
  logic [FLT_W-1:0] flt_cnt;
  logic             flt_flip;
  logic             fall;

  ps2_state_t            state, state_n;
  logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [PARITY_IDX-1:0] shreg, shreg_n;
  logic [WD_W-1:0]       wd_cnt, wd_n;
  logic                  push_req, push_n;
  logic                  perr_evt, perr_n;
  logic                  ferr_evt, ferr_n;

  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic ovf_set;

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
    end
  end

  // The filtered clock follows only after filter_len consecutive disagreeing cycles.
  assign flt_flip = (clk_s != filt) && (flt_cnt == FLT_W'(filter_len - 1));
  assign fall     = flt_flip && filt;

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      filt    <= 1'b1;
      flt_cnt <= '0;
    end else if (clk_s == filt) begin
      flt_cnt <= '0;
    end else if (flt_flip) begin
      filt    <= clk_s;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      wd_cnt   <= '0;
      push_req <= 1'b0;
      perr_evt <= 1'b0;
      ferr_evt <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      wd_cnt   <= wd_n;
      push_req <= push_n;
      perr_evt <= perr_n;
      ferr_evt <= ferr_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    wd_n      = wd_cnt;
    push_n    = 1'b0;
    perr_n    = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      IDLE: begin
        wd_n = '0;
        if (fall) begin
          if (!dat_s) begin
            state_n   = SHIFT;
            bit_cnt_n = BIT_CNT_W'(1);
          end else begin
            ferr_n = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (fall) begin
          wd_n = '0;
          if (bit_cnt == BIT_CNT_W'(STOP_IDX)) begin
            state_n = IDLE;
            if (!dat_s)        ferr_n = 1'b1;
            else if (!(^shreg)) perr_n = 1'b1;
            else               push_n = 1'b1;
          end else begin
            // Data LSB first then parity; after 9 shifts shreg = {parity, byte}.
            shreg_n   = {dat_s, shreg[PARITY_IDX-1:1]};
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end else if (wd_cnt == WD_W'(WD_LIMIT - 1)) begin
          state_n = IDLE;
          ferr_n  = 1'b1;
          wd_n    = '0;
        end else begin
          wd_n = wd_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign pop     = rd && valid;
  assign ovf_set = push_req && fifo_full && !pop;
  assign valid   = !fifo_empty;

  ps2_fifo #(
    .depth_log2 (fifo_depth_log2),
    .width      (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset_in),
    .push  (push_req),
    .din   (shreg[7:0]),
    .pop   (pop),
    .dout  (data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Set takes priority over a coincident clear.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (perr_evt)     parity_err <= 1'b1;
      else if (err_clr) parity_err <= 1'b0;
      if (ferr_evt)     frame_err  <= 1'b1;
      else if (err_clr) frame_err  <= 1'b0;
      if (ovf_set)      overflow   <= 1'b1;
      else if (err_clr) overflow   <= 1'b0;
    end
  end

endmodule
